// File: rtl/camera_pixel_assembler_if.sv
// Camera-side byte bus and pixel-side stream of the pixel assembler.
// The slave modport is the assembler; the master modport is the camera plus pixel consumer.
interface camera_pixel_assembler_if;
    logic [7:0] CAM_DATA;
    logic       CAM_HREF;
    logic       CAM_VSYNC;
    logic [7:0] PIXEL_OUT;
    logic [7:0] PIXEL_X;
    logic [7:0] PIXEL_Y;
    logic       PIXEL_VALID;
    logic       FRAME_DONE;
    logic [7:0] FRAME_LINES;
    logic       LINE_ERR;
    logic       FRAME_ERR;

    modport master (
        output CAM_DATA, CAM_HREF, CAM_VSYNC,
        input  PIXEL_OUT, PIXEL_X, PIXEL_Y, PIXEL_VALID,
        input  FRAME_DONE, FRAME_LINES, LINE_ERR, FRAME_ERR
    );

    modport slave (
        input  CAM_DATA, CAM_HREF, CAM_VSYNC,
        output PIXEL_OUT, PIXEL_X, PIXEL_Y, PIXEL_VALID,
        output FRAME_DONE, FRAME_LINES, LINE_ERR, FRAME_ERR
    );
endinterface

// File: rtl/camera_pixel_assembler.sv
// Packs RGB565 byte pairs from an HREF/VSYNC-framed camera bus into RGB323 pixels
// tagged with X/Y, and reports line-length and frame-framing errors.
module camera_pixel_assembler #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144
) (
    input  logic                     CLK,
    input  logic                     RESET,
    camera_pixel_assembler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VBLANK    = 3'd1,
        ST_LINE_WAIT = 3'd2,
        ST_BYTE_LO   = 3'd3,
        ST_BYTE_HI   = 3'd4
    } state_t;

    localparam logic [7:0] WIDTH_C  = 8'(SCREEN_WIDTH);
    localparam logic [7:0] HEIGHT_C = 8'(SCREEN_HEIGHT);

    // RGB565 hi/lo byte pair -> RGB323 (top bits of each channel).
    function automatic logic [7:0] pack_rgb323(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:1], lo[4:2]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] x_cnt_r, x_cnt_s;
    logic [7:0] y_cnt_r, y_cnt_s;
    logic [7:0] hi_r, hi_s;
    logic [7:0] pixel_out_r, pixel_out_s;
    logic [7:0] pixel_x_r, pixel_x_s;
    logic [7:0] pixel_y_r, pixel_y_s;
    logic       pixel_valid_r, pixel_valid_s;
    logic       frame_done_r, frame_done_s;
    logic [7:0] frame_lines_r, frame_lines_s;
    logic       line_err_r, line_err_s;
    logic       frame_err_r, frame_err_s;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; VSYNC outranks HREF in every capturing state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.CAM_VSYNC) state_s = ST_VBLANK;
                else               state_s = ST_IDLE;
            end
            ST_VBLANK: begin
                if (!bus.CAM_VSYNC) state_s = ST_LINE_WAIT;
                else                state_s = ST_VBLANK;
            end
            ST_LINE_WAIT: begin
                if (bus.CAM_VSYNC)     state_s = ST_VBLANK;
                else if (bus.CAM_HREF) state_s = ST_BYTE_LO;
                else                   state_s = ST_LINE_WAIT;
            end
            ST_BYTE_LO: begin
                if (bus.CAM_VSYNC)     state_s = ST_VBLANK;
                else if (bus.CAM_HREF) state_s = ST_BYTE_HI;
                else                   state_s = ST_LINE_WAIT;
            end
            ST_BYTE_HI: begin
                if (bus.CAM_VSYNC)     state_s = ST_VBLANK;
                else if (bus.CAM_HREF) state_s = ST_BYTE_LO;
                else                   state_s = ST_LINE_WAIT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and counter next values; pulses default low, pixel fields hold.
    always_comb begin
        x_cnt_s       = x_cnt_r;
        y_cnt_s       = y_cnt_r;
        hi_s          = hi_r;
        pixel_out_s   = pixel_out_r;
        pixel_x_s     = pixel_x_r;
        pixel_y_s     = pixel_y_r;
        pixel_valid_s = 1'b0;
        frame_done_s  = 1'b0;
        frame_lines_s = frame_lines_r;
        line_err_s    = 1'b0;
        frame_err_s   = frame_err_r;
        case (state_r)
            ST_IDLE: begin
                hi_s = hi_r;
            end
            ST_VBLANK: begin
                x_cnt_s = 8'd0;
                y_cnt_s = 8'd0;
            end
            ST_LINE_WAIT: begin
                if (bus.CAM_VSYNC) begin
                    frame_done_s  = 1'b1;
                    frame_lines_s = y_cnt_r;
                end else if (bus.CAM_HREF) begin
                    hi_s = bus.CAM_DATA;
                end else begin
                    hi_s = hi_r;
                end
            end
            ST_BYTE_LO: begin
                if (bus.CAM_VSYNC) begin
                    frame_err_s   = 1'b1;
                    frame_done_s  = 1'b1;
                    frame_lines_s = y_cnt_r;
                end else if (bus.CAM_HREF) begin
                    if ((x_cnt_r < WIDTH_C) && (y_cnt_r < HEIGHT_C)) begin
                        pixel_valid_s = 1'b1;
                        pixel_out_s   = pack_rgb323(hi_r, bus.CAM_DATA);
                        pixel_x_s     = x_cnt_r;
                        pixel_y_s     = y_cnt_r;
                    end else begin
                        pixel_valid_s = 1'b0;
                    end
                    x_cnt_s = sat_inc(x_cnt_r);
                end else begin
                    line_err_s = 1'b1;
                    y_cnt_s    = sat_inc(y_cnt_r);
                    x_cnt_s    = 8'd0;
                end
            end
            ST_BYTE_HI: begin
                if (bus.CAM_VSYNC) begin
                    frame_err_s   = 1'b1;
                    frame_done_s  = 1'b1;
                    frame_lines_s = y_cnt_r;
                end else if (bus.CAM_HREF) begin
                    hi_s = bus.CAM_DATA;
                end else begin
                    line_err_s = (x_cnt_r != WIDTH_C);
                    y_cnt_s    = sat_inc(y_cnt_r);
                    x_cnt_s    = 8'd0;
                end
            end
            default: begin
                x_cnt_s = 8'd0;
                y_cnt_s = 8'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_cnt_r       <= 8'd0;
            y_cnt_r       <= 8'd0;
            hi_r          <= 8'd0;
            pixel_out_r   <= 8'd0;
            pixel_x_r     <= 8'd0;
            pixel_y_r     <= 8'd0;
            pixel_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_lines_r <= 8'd0;
            line_err_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            x_cnt_r       <= x_cnt_s;
            y_cnt_r       <= y_cnt_s;
            hi_r          <= hi_s;
            pixel_out_r   <= pixel_out_s;
            pixel_x_r     <= pixel_x_s;
            pixel_y_r     <= pixel_y_s;
            pixel_valid_r <= pixel_valid_s;
            frame_done_r  <= frame_done_s;
            frame_lines_r <= frame_lines_s;
            line_err_r    <= line_err_s;
            frame_err_r   <= frame_err_s;
        end
    end

    assign bus.PIXEL_OUT   = pixel_out_r;
    assign bus.PIXEL_X     = pixel_x_r;
    assign bus.PIXEL_Y     = pixel_y_r;
    assign bus.PIXEL_VALID = pixel_valid_r;
    assign bus.FRAME_DONE  = frame_done_r;
    assign bus.FRAME_LINES = frame_lines_r;
    assign bus.LINE_ERR    = line_err_r;
    assign bus.FRAME_ERR   = frame_err_r;

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Scoreboard bench: line/frame-level reference model pushes expected events,
// a negedge monitor pops and compares whatever the assembler emits.
module tb_camera_pixel_assembler;

    localparam int W = 176;
    localparam int H = 144;
    localparam int K_PIX = 0;
    localparam int K_LERR = 1;
    localparam int K_FDONE = 2;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    camera_pixel_assembler_if bus ();

    camera_pixel_assembler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Model state: capture armed after a VSYNC fall, current line index, sticky framing error.
    bit  capturing = 1'b0;
    int  y_m = 0;
    bit  ferr_m = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int rgb323(input int hi, input int lo);
        int red, green, blue;
        red   = hi / 32;
        green = (hi / 2) % 4;
        blue  = (lo / 4) % 8;
        return red * 32 + green * 8 + blue;
    endfunction

    function automatic void push_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        bus.CAM_VSYNC = v;
        bus.CAM_HREF  = h;
        bus.CAM_DATA  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic vsync_pulse(input int hi_cycles, input int lo_cycles);
        if (capturing) push_ev(K_FDONE, y_m, 0, 0);
        for (int i = 0; i < hi_cycles; i++) cyc(1'b1, 1'b0, 8'($urandom));
        capturing = 1'b1;
        y_m = 0;
        for (int i = 0; i < lo_cycles; i++) cyc(1'b0, 1'b0, 8'($urandom));
    endtask

    // Drive one line of nbytes; fixed pattern if use_fixed else random bytes.
    task automatic send_line(input int nbytes, input bit use_fixed, input int fhi, input int flo);
        int hi_b, lo_b, npix;
        npix = nbytes / 2;
        for (int k = 0; k < nbytes; k++) begin
            if (k % 2 == 0) begin
                hi_b = use_fixed ? fhi : int'($urandom_range(0, 255));
                cyc(1'b0, 1'b1, 8'(hi_b));
            end else begin
                lo_b = use_fixed ? flo : int'($urandom_range(0, 255));
                if (capturing && (k / 2) < W && y_m < H)
                    push_ev(K_PIX, rgb323(hi_b, lo_b), k / 2, y_m);
                cyc(1'b0, 1'b1, 8'(lo_b));
            end
        end
        if (capturing) begin
            if ((nbytes % 2) != 0 || npix != W) push_ev(K_LERR, 0, 0, 0);
            y_m = (y_m >= 255) ? 255 : y_m + 1;
        end
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) cyc(1'b0, 1'b0, 8'($urandom));
    endtask

    // Line cut short by VSYNC after npix pixels (plus a dangling hi byte if half).
    task automatic abort_line(input int npix, input bit half);
        int hi_b, lo_b;
        for (int k = 0; k < npix; k++) begin
            hi_b = int'($urandom_range(0, 255));
            lo_b = int'($urandom_range(0, 255));
            cyc(1'b0, 1'b1, 8'(hi_b));
            push_ev(K_PIX, rgb323(hi_b, lo_b), k, y_m);
            cyc(1'b0, 1'b1, 8'(lo_b));
        end
        if (half) cyc(1'b0, 1'b1, 8'($urandom));
        push_ev(K_FDONE, y_m, 0, 0);
        ferr_m = 1'b1;
        cyc(1'b1, 1'b1, 8'($urandom));
        cyc(1'b1, 1'b0, 8'($urandom));
        cyc(1'b1, 1'b0, 8'($urandom));
        y_m = 0;
        cyc(1'b0, 1'b0, 8'($urandom));
        cyc(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pixel_out"},   int'(bus.PIXEL_OUT), 0);
        chk({tag, "_pixel_x"},     int'(bus.PIXEL_X), 0);
        chk({tag, "_pixel_y"},     int'(bus.PIXEL_Y), 0);
        chk({tag, "_pixel_valid"}, int'(bus.PIXEL_VALID), 0);
        chk({tag, "_frame_done"},  int'(bus.FRAME_DONE), 0);
        chk({tag, "_frame_lines"}, int'(bus.FRAME_LINES), 0);
        chk({tag, "_line_err"},    int'(bus.LINE_ERR), 0);
        chk({tag, "_frame_err"},   int'(bus.FRAME_ERR), 0);
    endtask

    // Monitor: every emitted event must match the head of the expectation queue.
    always @(negedge CLK) begin : monitor
        ev_t e;
        if (bus.PIXEL_VALID) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_PIX) begin
                checks++; errors++;
                $display("FAIL pixel_event actual=strobe x=%0d y=%0d required=%s", bus.PIXEL_X, bus.PIXEL_Y,
                         (exp_q.size() == 0) ? "none" : "other_event");
            end else begin
                e = exp_q.pop_front();
                chk("pixel_out", int'(bus.PIXEL_OUT), e.a);
                chk("pixel_x", int'(bus.PIXEL_X), e.b);
                chk("pixel_y", int'(bus.PIXEL_Y), e.c);
            end
        end
        if (bus.LINE_ERR) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_LERR) begin
                checks++; errors++;
                $display("FAIL line_err_event actual=pulse required=%s", (exp_q.size() == 0) ? "none" : "other_event");
            end else begin
                e = exp_q.pop_front();
                chk("line_err", int'(bus.LINE_ERR), 1);
            end
        end
        if (bus.FRAME_DONE) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_FDONE) begin
                checks++; errors++;
                $display("FAIL frame_done_event actual=pulse lines=%0d required=%s", bus.FRAME_LINES,
                         (exp_q.size() == 0) ? "none" : "other_event");
            end else begin
                e = exp_q.pop_front();
                chk("frame_lines", int'(bus.FRAME_LINES), e.a);
            end
        end
    end

    initial begin
        int n_lines, len;
        int lens[6];
        bus.CAM_VSYNC = 1'b0;
        bus.CAM_HREF  = 1'b0;
        bus.CAM_DATA  = 8'h00;
        RESET = 1'b1;
        @(posedge CLK); #1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check_all_zero("reset");
        RESET = 1'b0;

        // Bytes before the first VSYNC must be ignored.
        send_line(2 * W, 1'b0, 0, 0);

        // Two clean lines, fixed pattern.
        vsync_pulse(3, 2);
        send_line(2 * W, 1'b1, 8'hE0, 8'h1C);
        send_line(2 * W, 1'b1, 8'hE0, 8'h1C);
        vsync_pulse(3, 2);

        // Full frame.
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1, 8'h07, 8'h00);
        vsync_pulse(2, 2);
        chk("full_frame_err", int'(bus.FRAME_ERR), 0);

        // Odd byte count, over-long line, clean line, then VSYNC abort on line 3.
        send_line(2 * W - 1, 1'b0, 0, 0);
        send_line(2 * (W + 4), 1'b0, 0, 0);
        send_line(2 * W, 1'b0, 0, 0);
        abort_line(50, 1'b1);
        chk("abort_frame_err", int'(bus.FRAME_ERR), int'(ferr_m));

        // Random line lengths; FRAME_ERR stays sticky.
        lens = '{2 * W, 2 * W - 1, 2 * W + 1, 340, 2 * (W + 4), 0};
        n_lines = int'($urandom_range(2, 5));
        for (int l = 0; l < n_lines; l++) begin
            len = lens[$urandom_range(0, 5)];
            if (len == 0) len = int'($urandom_range(1, 400));
            send_line(len, 1'b0, 0, 0);
        end
        vsync_pulse(2, 2);
        chk("sticky_frame_err", int'(bus.FRAME_ERR), int'(ferr_m));

        // Reset between hi and lo bytes.
        send_line(2 * W, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 8'($urandom));
        chk("pre_reset_queue", exp_q.size(), 0);
        RESET = 1'b1;
        cyc(1'b0, 1'b1, 8'($urandom));
        RESET = 1'b0;
        capturing = 1'b0;
        y_m = 0;
        ferr_m = 1'b0;
        exp_q.delete();
        check_all_zero("midline_reset");
        send_line(2 * W, 1'b0, 0, 0);
        vsync_pulse(2, 2);
        send_line(2 * W, 1'b0, 0, 0);
        vsync_pulse(2, 2);
        chk("post_reset_frame_err", int'(bus.FRAME_ERR), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        chk("drain_pending_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
